// File: rtl/sprind_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : sprind_alu_seq
// Brief    : Single-issue ALU sequencer (IDLE -> EXEC -> WB) with flags
//            register. Optional condition evaluator: SPRIND_ALU_SEQ_COND_EN.
// Revision : 1.0  initial release
// ============================================================================
module sprind_alu_seq #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [4:0]       i_req_opcode,
    input  logic [WIDTH-1:0] i_req_a,
    input  logic [WIDTH-1:0] i_req_b,
    input  logic [2:0]       i_req_rd,
    input  logic             i_req_setflags,
    output logic [4:0]       o_alu_opcode,
    output logic [WIDTH-1:0] o_alu_input0,
    output logic [WIDTH-1:0] o_alu_input1,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_carry,
    input  logic             i_alu_overflow,
    input  logic             i_alu_zero,
    input  logic             i_alu_sign,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [2:0]       o_wb_rd,
    output logic [WIDTH-1:0] o_wb_data,
    output logic [3:0]       o_flags
`ifdef SPRIND_ALU_SEQ_COND_EN
    ,
    input  logic [2:0]       i_cond,
    output logic             o_cond_true
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] c_CNT_LAST = 3'(ALU_LATENCY - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_cnt;
    logic       r_setflags;
    logic [2:0] r_rd;
    logic       w_accept;
    logic       w_capture;
    logic       w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_EXEC;
            S_EXEC: if (w_cnt_last) w_next_state = S_WB;
            S_WB: begin
                if (i_wb_ready) begin
                    w_next_state = w_accept ? S_EXEC : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Ready in WB depends combinationally on i_wb_ready so a new request can
    // overlap the writeback handshake without a bubble.
    always_comb begin
        o_req_ready = 1'b0;
        o_wb_valid  = 1'b0;
        w_capture   = 1'b0;
        if (!rst) begin
            o_req_ready = (r_state == S_IDLE) || ((r_state == S_WB) && i_wb_ready);
        end
        o_wb_valid = (r_state == S_WB);
        w_capture  = (r_state == S_EXEC) && w_cnt_last;
        w_accept   = i_req_valid && o_req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_cnt <= 3'd0;
        end else if ((r_state == S_EXEC) && !w_cnt_last) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_alu_opcode <= 5'd0;
            o_alu_input0 <= '0;
            o_alu_input1 <= '0;
            r_rd         <= 3'd0;
            r_setflags   <= 1'b0;
            o_wb_rd      <= 3'd0;
            o_wb_data    <= '0;
            o_flags      <= 4'b0000;
        end else begin
            if (w_accept) begin
                o_alu_opcode <= i_req_opcode;
                o_alu_input0 <= i_req_a;
                o_alu_input1 <= i_req_b;
                r_rd         <= i_req_rd;
                r_setflags   <= i_req_setflags;
            end
            if (w_capture) begin
                o_wb_data <= i_alu_result;
                o_wb_rd   <= r_rd;
                if (r_setflags) begin
                    o_flags <= {i_alu_carry, i_alu_overflow, i_alu_zero, i_alu_sign};
                end
            end
        end
    end

`ifdef SPRIND_ALU_SEQ_COND_EN
    // o_flags = {C, V, Z, S}
    always_comb begin
        o_cond_true = 1'b0;
        case (i_cond)
            3'd0: o_cond_true = o_flags[1];
            3'd1: o_cond_true = !o_flags[1];
            3'd2: o_cond_true = o_flags[3];
            3'd3: o_cond_true = !o_flags[3];
            3'd4: o_cond_true = o_flags[0];
            3'd5: o_cond_true = o_flags[0] ^ o_flags[2];
            3'd6: o_cond_true = !(o_flags[0] ^ o_flags[2]);
            default: o_cond_true = 1'b1;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: doc/sprind_alu_seq.md
SPRIND_ALU_SEQ -- requirements
Module: sprind_alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: data width of operands, results and ALU ports.
REQ-002 Parameter ALU_LATENCY, default 1: cycles from ALU inputs stable to ALU outputs valid; legal range 1..7.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req_valid  input  1  issue request present.
REQ-006 o_req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 i_req_opcode  input  5  ALU opcode to issue.
REQ-008 i_req_a, i_req_b  input  WIDTH each  operands 0 and 1.
REQ-009 i_req_rd  input  3  destination register index.
REQ-010 i_req_setflags  input  1  request updates the flags register.
REQ-011 o_alu_opcode  output  5; o_alu_input0, o_alu_input1  output  WIDTH each; these drive the ALU.
REQ-012 i_alu_result  input  WIDTH; i_alu_carry, i_alu_overflow, i_alu_zero, i_alu_sign  input  1 each; from the ALU.
REQ-013 o_wb_valid  output  1; i_wb_ready  input  1; o_wb_rd  output  3; o_wb_data  output  WIDTH; writeback handshake.
REQ-014 o_flags  output  4  architectural flags {C,V,Z,S}, bit 3 = C.

Function
REQ-015 The sequencer SHALL implement states IDLE, EXEC, WB.
REQ-016 o_req_ready SHALL be 1 in IDLE, and in WB when i_wb_ready is 1 (combinational path from i_wb_ready permitted); 0 otherwise.
REQ-017 Acceptance SHALL occur when i_req_valid and o_req_ready are both 1; opcode, operands, rd, setflags latched at that edge; state goes to EXEC.
REQ-018 o_alu_opcode/o_alu_input0/o_alu_input1 SHALL be registered, updated only on acceptance, and held stable through EXEC and WB.
REQ-019 In EXEC a 3-bit counter SHALL count ALU_LATENCY cycles; on the edge ending the last EXEC cycle, i_alu_result is captured into o_wb_data and state goes to WB.
REQ-020 At that same capture edge, if latched setflags is 1, o_flags SHALL load {carry,overflow,zero,sign}; otherwise o_flags holds.
REQ-021 Issue-to-o_wb_valid latency SHALL be exactly ALU_LATENCY+1 cycles after the acceptance edge (ALU_LATENCY=1: o_wb_valid high 2 cycles after acceptance).
REQ-022 In WB, o_wb_valid SHALL be 1 with o_wb_rd/o_wb_data stable until i_wb_ready is 1.
REQ-023 On WB handshake with no acceptance, state SHALL go to IDLE; with simultaneous acceptance, state SHALL go directly to EXEC (back-to-back, no bubble).
REQ-024 i_req_* SHALL be ignored whenever no acceptance occurs; i_alu_* SHALL be ignored outside the capture edge.
REQ-025 Arithmetic is entirely in the ALU; the sequencer SHALL pass data unmodified.

Reset
REQ-026 While rst is 1 at a clock edge: state IDLE, counter 0, o_flags 4'b0000, o_wb_valid 0, o_wb_rd 0, o_wb_data 0, ALU output registers 0; o_req_ready 0 while rst is asserted.
REQ-027 Reset mid-EXEC or mid-WB SHALL drop the in-flight operation with no writeback and no flag update.
REQ-028 o_req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro SPRIND_ALU_SEQ_COND_EN defined: ports i_cond (input 3) and o_cond_true (output 1) exist; o_cond_true is combinational from o_flags: 0 EQ=Z, 1 NE=!Z, 2 CS=C, 3 CC=!C, 4 MI=S, 5 LT=S^V, 6 GE=!(S^V), 7 AL=1.
REQ-030 Macro undefined: i_cond and o_cond_true SHALL be absent; all other behaviour identical.

Verification
REQ-031 ALU_LATENCY=1, issue opcode 0, a=16'h0003, b=16'h0004, rd=2, setflags=1, ALU returns 16'h0007, flags 0 -> o_wb_valid high 2 cycles after acceptance, o_wb_data=16'h0007, o_wb_rd=2, o_flags=4'b0000.
REQ-032 ALU returns 16'h0000 with carry=1, zero=1, setflags=1 -> o_flags=4'b1010; repeat with setflags=0 and flags 0 -> o_flags stays 4'b1010.
REQ-033 i_wb_ready held 0 for 5 cycles in WB -> o_wb_valid/o_wb_data stable all 5 cycles, o_req_ready 0; release -> handshake, IDLE.
REQ-034 i_wb_ready=1 and new i_req_valid=1 in same WB cycle -> both handshakes complete, next cycle in EXEC with new operands on o_alu_input0/1.
REQ-035 ALU_LATENCY=4, rst pulsed in second EXEC cycle -> no o_wb_valid ever for that request, o_flags=0, o_req_ready=1 cycle after rst falls.
REQ-036 SPRIND_ALU_SEQ_COND_EN defined, o_flags=4'b0001 (S=1,V=0) -> i_cond=5 gives o_cond_true=1, i_cond=6 gives 0, i_cond=7 gives 1.
